// File: rtl/dsc_mul_drv.sv
// dsc_mul_drv: on-chip stimulus/checker for one 3-input dsc_mul instance.
// Each test loads operands (all-ones first, then LFSR slices), runs the
// multiplier until mul_ov, then compares z with the exact product and
// accumulates cycle statistics.
// Optional watchdog: define DSC_MUL_DRV_TIMEOUT_EN.
module dsc_mul_drv #(
   parameter int          W           = 4,
   parameter int          N_W         = 8,
   parameter int          CYC_W       = 20,
   parameter int          ACC_W       = 32,
   parameter logic [31:0] SEED        = 32'hACE1_5EED,
   parameter int          TIMEOUT_CYC = (1 << (3*W)) + 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [N_W-1:0]     i_num_tests,
   output logic               o_mul_rst,
   output logic               o_mul_en,
   output logic [W-1:0]       o_mul_a,
   output logic [W-1:0]       o_mul_b,
   output logic [W-1:0]       o_mul_c,
   input  logic [3*W-1:0]     i_mul_z,
   input  logic               i_mul_ov,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_pass,
   output logic [15:0]        o_err_count,
   output logic [CYC_W-1:0]   o_last_cycles,
   output logic [ACC_W-1:0]   o_cycle_acc,
   output logic               o_timeout
);
   localparam int ZW = 3*W;
`ifdef DSC_MUL_DRV_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam logic [CYC_W:0]   TO_LIM  = (CYC_W+1)'(TIMEOUT_CYC);
   localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(TIMEOUT_CYC);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CHECK, S_DONE} state_t;
   state_t r_state, w_next;

   logic [N_W-1:0]   r_remaining;
   logic             r_first;     // next LOAD is the first test of the run
   logic             r_skip;      // current test timed out; no compare
   logic [31:0]      r_lfsr;
   logic [ZW-1:0]    r_expected;
   logic [CYC_W-1:0] r_cyc;
   logic [15:0]      r_err;
   logic             r_timeout;

   logic [W-1:0]     w_a, w_b, w_c;
   logic [ZW-1:0]    w_prod;
   logic [CYC_W-1:0] w_cyc_inc;
   logic [CYC_W:0]   w_cyc_p1;
   logic             w_to;
   logic [15:0]      w_err_inc;
   logic [31:0]      w_lfsr_nxt;

   assign w_a    = r_first ? {W{1'b1}} : r_lfsr[W-1:0];
   assign w_b    = r_first ? {W{1'b1}} : r_lfsr[2*W-1:W];
   assign w_c    = r_first ? {W{1'b1}} : r_lfsr[3*W-1:2*W];
   assign w_prod = {{(ZW-W){1'b0}}, w_a} * {{(ZW-W){1'b0}}, w_b}
                 * {{(ZW-W){1'b0}}, w_c};

   assign w_cyc_inc  = (&r_cyc) ? r_cyc : r_cyc + 1'b1;
   assign w_cyc_p1   = {1'b0, r_cyc} + 1'b1;
   assign w_to       = TO_EN && (r_state == S_RUN) && !i_mul_ov && (w_cyc_p1 >= TO_LIM);
   assign w_err_inc  = (&r_err) ? r_err : r_err + 1'b1;
   // Galois LFSR, taps 32,22,2,1
   assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);

   // state register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = (i_num_tests != '0) ? S_LOAD : S_DONE;
         S_LOAD:  w_next = S_RUN;
         S_RUN:   if (i_mul_ov || w_to) w_next = S_CHECK;
         S_CHECK: w_next = (r_remaining == N_W'(1)) ? S_DONE : S_LOAD;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // registered control outputs, decoded from the state being entered
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_mul_rst <= 1'b1;
         o_mul_en  <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
      end else begin
         o_mul_rst <= !((w_next == S_RUN) || (w_next == S_CHECK));
         o_mul_en  <= (w_next == S_RUN);
         o_busy    <= (w_next != S_IDLE);
         o_done    <= (w_next == S_DONE);
      end
   end

   // test datapath: operands, cycle counting, compare and statistics
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_remaining   <= '0;
         r_first       <= 1'b0;
         r_skip        <= 1'b0;
         r_lfsr        <= SEED;
         r_expected    <= '0;
         r_cyc         <= '0;
         r_err         <= '0;
         r_timeout     <= 1'b0;
         o_mul_a       <= '0;
         o_mul_b       <= '0;
         o_mul_c       <= '0;
         o_last_cycles <= '0;
         o_cycle_acc   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (i_start) begin
               r_remaining <= i_num_tests;
               r_first     <= 1'b1;
               r_err       <= '0;
               r_timeout   <= 1'b0;
               o_cycle_acc <= '0;
            end
            S_LOAD: begin
               o_mul_a    <= w_a;
               o_mul_b    <= w_b;
               o_mul_c    <= w_c;
               r_expected <= w_prod;
               r_cyc      <= '0;
               r_first    <= 1'b0;
               r_skip     <= 1'b0;
            end
            S_RUN: begin
               r_cyc <= w_cyc_inc;
               if (i_mul_ov) begin
                  o_last_cycles <= w_cyc_inc;
               end else if (w_to) begin
                  o_last_cycles <= TO_LAST;
                  r_timeout     <= 1'b1;
                  r_err         <= w_err_inc;
                  r_skip        <= 1'b1;
               end
            end
            S_CHECK: begin
               if (!r_skip && (i_mul_z != r_expected)) r_err <= w_err_inc;
               o_cycle_acc <= o_cycle_acc + {{(ACC_W-CYC_W){1'b0}}, o_last_cycles};
               r_lfsr      <= w_lfsr_nxt;
               r_remaining <= r_remaining - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_err_count = r_err;
   assign o_timeout   = r_timeout;
   assign o_pass      = (r_err == 16'h0);

endmodule

// File: doc/dsc_mul_drv.md
# dsc_mul_drv

Synthesizable stimulus/checker initiator for the 3-input deterministic stochastic multiplier `dsc_mul`, which is the responder. It drives the operands, enable and reset, waits for the overflow/finished flag, and checks `z` against the exact binary product. It also accumulates cycle statistics so on-chip and gate-level power runs need no simulation-only bench. It sits between a host/control register block and one `dsc_mul` instance.

## Interface
- `W`, default 4: operand width; `dsc_mul` result is 3*W bits; legal range 2..10.
- `N_W`, default 8: width of the test-count input.
- `CYC_W`, default 20: width of the per-test cycle counter and `last_cycles`.
- `ACC_W`, default 32: width of `cycle_acc`.
- `SEED`, default 32'hACE1_5EED: LFSR reset value; must be nonzero.
- `TIMEOUT_CYC`, default (1<<(3*W))+16: watchdog limit, used only with the macro.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a test run; sampled only in IDLE.
- `num_tests` in N_W: number of tests in the run; sampled with `start`.
- `mul_rst` out 1: reset to `dsc_mul`.
- `mul_en` out 1: enable to `dsc_mul`.
- `mul_a`, `mul_b`, `mul_c` out W each: operands.
- `mul_z` in 3*W: `dsc_mul` result.
- `mul_ov` in 1: `dsc_mul` finished flag.
- `busy` out 1: a run is in progress.
- `done` out 1: one-cycle pulse at end of run.
- `pass` out 1: high when `err_count`==0; valid after `done`.
- `err_count` out 16: mismatches in the run; saturates at 16'hFFFF.
- `last_cycles` out CYC_W: RUN cycles taken by the most recent test.
- `cycle_acc` out ACC_W: sum of `last_cycles` over the run; wraps modulo 2^ACC_W.
- `timeout` out 1: sticky watchdog flag for the run.

## Operation
- States: IDLE, LOAD, RUN, CHECK, DONE.
- **IDLE**
  - `start`=1 and `num_tests`!=0: latch `num_tests` into `remaining`; clear `err_count`, `cycle_acc` and `timeout`; go to LOAD.
  - `start`=1 and `num_tests`==0: clear the same statistics and go straight to DONE.
- **LOAD** (1 cycle)
  - Drive `mul_rst`=1 and `mul_en`=0.
  - Register operands:
    - first test of a run: all-ones on a, b and c;
    - later tests: a=lfsr[W-1:0], b=lfsr[2W-1:W], c=lfsr[3W-1:2W].
  - Register `expected` = a*b*c at full 3*W width; no truncation is possible.
  - Clear `cyc` to 0.
- **RUN**
  - Drive `mul_rst`=0 and `mul_en`=1; operands stay stable.
  - `cyc` increments every cycle and saturates at all-ones.
  - `mul_ov` sampled high: `last_cycles`<=`cyc`+1, then go to CHECK.
- **CHECK** (1 cycle)
  - Drive `mul_en`=0 and `mul_rst`=0 so `z` stays frozen.
  - If `mul_z`!=`expected`, increment `err_count` (saturating).
  - `cycle_acc` += `last_cycles`.
  - Advance the LFSR one step: 32-bit Galois, taps 32,22,2,1. It advances only here.
  - Decrement `remaining`; if the result is 0 go to DONE, else go to LOAD.
- **DONE** (1 cycle): `done`=1, then go to IDLE.
- Outside LOAD/RUN/CHECK, `mul_rst` is held at 1, so the DUT stays reset while idle.
- `busy`=1 in LOAD, RUN, CHECK and DONE.
- `start` is ignored while `busy`.
- `pass` = (`err_count`==0), combinational.
- The LFSR is not reseeded by `start`. Consecutive runs continue the sequence; only `rst` reloads `SEED`.

## Timing
- Reset values:
  - state IDLE; `mul_rst`=1, `mul_en`=0, operands 0;
  - `busy`=0, `done`=0, `pass`=1, `err_count`=0, `last_cycles`=0, `cycle_acc`=0, `timeout`=0;
  - lfsr=`SEED`.
- `rst` mid-run aborts immediately to the reset values; there is no partial `done`.
- `start` to the first `mul_en`=1: 2 cycles (IDLE→LOAD→RUN).
- Per-test overhead beyond the DUT latency is 2 cycles (LOAD, CHECK).
- A DUT raising `mul_ov` on the first RUN cycle gives `last_cycles`=1.
- `mul_ov` is ignored outside RUN, including a stale high in LOAD.
- All outputs are registered except `pass`.

## Configuration
- `DSC_MUL_DRV_TIMEOUT_EN` defined:
  - in RUN, if `cyc`+1 reaches `TIMEOUT_CYC` with `mul_ov` still low, set `timeout`=1 (sticky);
  - increment `err_count` and set `last_cycles`=`TIMEOUT_CYC`;
  - go to CHECK, where the compare is skipped for that test.
- Macro undefined: no watchdog; RUN waits indefinitely; `timeout` is tied to 0.

## Test plan
- **Single max corner.** Behavioral DUT model raises `mul_ov` after 100 cycles with z=a*b*c; `num_tests`=1. Expect operands 15/15/15 (W=4); z 3375 accepted; `err_count`=0; `pass`=1; `last_cycles`=100; `cycle_acc`=100; `done` pulses once.
- **Ten-test run.** Model latency 4096 and correct product; `num_tests`=10. Expect `cycle_acc`=40960; first operands all-ones; remaining operands match a reference LFSR from `SEED`; `busy` is high for exactly 10*(4096+2)+1 cycles.
- **Error injection.** Model returns product+1 on tests 3 and 7 of 10. Expect `err_count`=2 and `pass`=0 after `done`.
- **Boundary cases.**
  - `num_tests`=0: `done` 1 cycle after `start`; no `mul_en`; statistics cleared.
  - `start` pulsed during RUN: no effect.
- **Reset mid-RUN.** Assert `rst` at RUN cycle 50. Next cycle shows the reset values with `mul_rst`=1; a subsequent `start` replays all-ones then the `SEED`-based operands.
- **Timeout (macro on).** Model never raises `mul_ov`. Expect `timeout`=1, `err_count`=1, `last_cycles`=4112; the run completes. Macro off: `busy` stays high indefinitely and `timeout`=0.
